// File: rtl/cam_capture_ctrl.sv
// Camera capture controller: AXI4-Lite config, parallel camera sampling,
// byte packing into 32-bit words presented on a valid/ready write port.
module cam_capture_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        pclk,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  data,
  output logic        pwdn,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data
);

  typedef enum logic [1:0] {IDLE, WAIT_START, FRAME} state_t;

  state_t      state;
  logic        ctrl_en, test_en, ovf;
  logic [31:0] base, base_lat, base_wr, rd_mux;
  logic [15:0] frame_cnt;
  logic        s1_pclk, s2_pclk, s1_vsync, s2_vsync, s1_href;
  logic [7:0]  s1_data, tcnt, cap_byte;
  logic [1:0]  lane;
  logic [19:0] word_idx;
  logic [23:0] pack;
  logic        wr_hs, rd_hs, sts_clr, cap, vs_fall, vs_rise, busy;
  logic        unused_addr_bits;

  assign unused_addr_bits = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_wready = s_axi_awready;
  assign s_axi_bresp  = 2'b00;
  assign s_axi_rresp  = 2'b00;

  assign wr_hs   = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign rd_hs   = s_axi_arready & s_axi_arvalid;
  assign sts_clr = wr_hs && (s_axi_awaddr[3:2] == 2'd2) && s_axi_wstrb[0] && s_axi_wdata[1];
  assign busy    = (state == FRAME);
  assign vs_fall = ~s1_vsync & s2_vsync;
  assign vs_rise = s1_vsync & ~s2_vsync;
  assign cap     = s1_pclk & ~s2_pclk & s1_href;
  assign cap_byte = test_en ? tcnt : s1_data;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    base_wr = base;
    for (int i = 0; i < 4; i++)
      if (s_axi_wstrb[i]) base_wr[8*i +: 8] = s_axi_wdata[8*i +: 8];
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[3:2])
      2'd0: rd_mux[0] = ctrl_en;
      2'd1: rd_mux    = base;
      2'd2: rd_mux    = {frame_cnt, 14'b0, ovf, busy};
      default: rd_mux[0] = test_en;
    endcase
  end

  // AXI4-Lite slave and configuration registers; reads see pre-write values.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_awready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      ctrl_en       <= 1'b0;
      test_en       <= 1'b0;
      base          <= '0;
      pwdn          <= 1'b1;
    end else begin
      s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
      s_axi_arready <= s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;
      pwdn          <= ~ctrl_en;
      if (wr_hs) begin
        s_axi_bvalid <= 1'b1;
        case (s_axi_awaddr[3:2])
          2'd0: if (s_axi_wstrb[0]) ctrl_en <= s_axi_wdata[0];
          2'd1: base <= base_wr & 32'hFFFF_FFFC;
          2'd3: if (s_axi_wstrb[0]) test_en <= s_axi_wdata[0];
          default: ;
        endcase
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // Input sampling, frame FSM and word packing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s1_pclk   <= 1'b0;
      s2_pclk   <= 1'b0;
      s1_vsync  <= 1'b0;
      s2_vsync  <= 1'b0;
      s1_href   <= 1'b0;
      s1_data   <= '0;
      lane      <= '0;
      word_idx  <= '0;
      tcnt      <= '0;
      pack      <= '0;
      base_lat  <= '0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      s1_pclk  <= pclk;
      s2_pclk  <= s1_pclk;
      s1_vsync <= vsync;
      s2_vsync <= s1_vsync;
      s1_href  <= href;
      s1_data  <= data;
      if (wr_valid && wr_ready) wr_valid <= 1'b0;
      if (sts_clr) ovf <= 1'b0;
      if (!ctrl_en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= WAIT_START;
          WAIT_START: if (vs_fall) begin
            state    <= FRAME;
            word_idx <= '0;
            lane     <= '0;
            tcnt     <= '0;
            base_lat <= base;
          end
          FRAME: if (vs_rise) begin
            state     <= WAIT_START;
            frame_cnt <= frame_cnt + 16'd1;
          end else if (cap) begin
            tcnt <= tcnt + 8'd1;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              word_idx <= word_idx + 20'd1;
              // A word finishing while the previous one is still stalled is dropped.
              if (wr_valid && !wr_ready) begin
                ovf <= 1'b1;
              end else begin
                wr_valid <= 1'b1;
                wr_data  <= {cap_byte, pack};
                wr_addr  <= base_lat + {10'b0, word_idx, 2'b00};
              end
            end else begin
              pack[{lane, 3'b000} +: 8] <= cap_byte;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed self-checking bench for cam_capture_ctrl: register access,
// test-pattern and camera capture, overflow, frame count and mid-frame reset.
module tb_cam_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic        s_axi_rvalid, s_axi_rready;
  logic        pclk, vsync, href;
  logic [7:0]  data;
  logic        pwdn, wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] wq[$];

  cam_capture_ctrl dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data), .pwdn(pwdn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Record every accepted word; sampled just after the falling edge, ahead of the accepting rising edge.
  initial forever begin
    @(negedge clk);
    #1;
    if (wr_valid && wr_ready) wq.push_back({wr_addr, wr_data});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] val, input logic [3:0] strb);
    int n = 0;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_wdata = val; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axi_awready && n < 20);
    if (!s_axi_awready) begin
      check("aw_timeout", 32'd0, 32'd1);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      return;
    end
    check("wready", s_axi_wready, 32'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("bvalid", s_axi_bvalid, 32'd1);
    check("bresp", s_axi_bresp, 32'd0);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    check("bvalid_clr", s_axi_bvalid, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] val);
    int n = 0;
    val = '0;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 20);
    if (!s_axi_arready) begin
      check("ar_timeout", 32'd0, 32'd1);
      s_axi_arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check("rvalid", s_axi_rvalid, 32'd1);
    check("rresp", s_axi_rresp, 32'd0);
    val = s_axi_rdata;
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(addr, v);
    check(tag, v, exp);
  endtask

  task automatic pclk_byte(input logic [7:0] b);
    @(negedge clk);
    data = b; pclk = 1'b1;
    repeat (2) @(negedge clk);
    pclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] addr, input logic [31:0] wdat);
    logic [63:0] w;
    if (wq.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      w = wq.pop_front();
      check({tag, "_addr"}, w[63:32], addr);
      check({tag, "_data"}, w[31:0], wdat);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, s_axi_awready, 32'd0);
    check({tag, "_arready"}, s_axi_arready, 32'd0);
    check({tag, "_bvalid"}, s_axi_bvalid, 32'd0);
    check({tag, "_rvalid"}, s_axi_rvalid, 32'd0);
    check({tag, "_wr_valid"}, wr_valid, 32'd0);
    check({tag, "_wr_addr"}, wr_addr, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_pwdn"}, pwdn, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    pclk = 1'b0; vsync = 1'b1; href = 1'b0; data = '0; wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Register access
    check_reg("status_rst", 4'h8, 32'h0000_0000);
    axi_write(4'h4, 32'h44A0_0003, 4'hF);
    check_reg("base_rd", 4'h4, 32'h44A0_0000);
    axi_write(4'h4, 32'hFFFF_FFFF, 4'b0010);
    check_reg("base_strb", 4'h4, 32'h44A0_FF00);
    axi_write(4'h4, 32'h44A0_0000, 4'hF);

    // Enable; vsync still high so no frame yet
    axi_write(4'h0, 32'h1, 4'hF);
    check("pwdn_en", pwdn, 32'd0);
    check_reg("ctrl_rd", 4'h0, 32'h1);
    check_reg("busy_wait", 4'h8, 32'h0);

    // Test-pattern frame
    axi_write(4'hC, 32'h1, 4'hF);
    wr_ready = 1'b1; href = 1'b1;
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    check_reg("busy_frame", 4'h8, 32'h1);
    for (int i = 0; i < 8; i++) pclk_byte(8'h5A);
    repeat (2) @(negedge clk);
    check("tp_count", wq.size(), 32'd2);
    expect_word("tp_w0", 32'h44A0_0000, 32'h0302_0100);
    expect_word("tp_w1", 32'h44A0_0004, 32'h0706_0504);

    // Camera data in the same frame
    axi_write(4'hC, 32'h0, 4'hF);
    pclk_byte(8'hAA); pclk_byte(8'hBB); pclk_byte(8'hCC); pclk_byte(8'hDD);
    repeat (2) @(negedge clk);
    expect_word("cam_w", 32'h44A0_0008, 32'hDDCC_BBAA);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    check_reg("frame_end", 4'h8, 32'h0001_0000);

    // Overflow: downstream stalled across two words
    wr_ready = 1'b0;
    wq.delete();
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) pclk_byte(8'h11 + 8'(i));
    repeat (2) @(negedge clk);
    check("ovf_valid", wr_valid, 32'd1);
    check("ovf_addr", wr_addr, 32'h44A0_0000);
    check("ovf_data", wr_data, 32'h1413_1211);
    check_reg("ovf_set", 4'h8, 32'h0001_0003);
    axi_write(4'h8, 32'h2, 4'h1);
    check_reg("ovf_clr", 4'h8, 32'h0001_0001);
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovf_count", wq.size(), 32'd1);
    expect_word("ovf_w", 32'h44A0_0000, 32'h1413_1211);
    check("ovf_drop", wr_valid, 32'd0);

    // Reset mid-frame with a partial word pending
    pclk_byte(8'h21); pclk_byte(8'h22);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("mid_rst");
    check_reg("status_mid_rst", 4'h8, 32'h0);
    check_reg("base_mid_rst", 4'h4, 32'h0);
    wq.delete();
    axi_write(4'h4, 32'h1000_0000, 4'hF);
    axi_write(4'h0, 32'h1, 4'h1);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    check_reg("busy_after_rst", 4'h8, 32'h1);
    pclk_byte(8'h31); pclk_byte(8'h32); pclk_byte(8'h33); pclk_byte(8'h34);
    repeat (2) @(negedge clk);
    check("post_rst_count", wq.size(), 32'd1);
    expect_word("post_rst_w", 32'h1000_0000, 32'h3433_3231);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
